// File: rtl/ddc_mixer_pkg.sv
// Shared constants and width helpers for the DDC mixer and its round/saturate stage.
package ddc_mixer_pkg;

  localparam int SAT_CNT_W = 16;
  localparam int STAGES    = 3;

  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

  // Full-precision product width of a DATA_W x NCO_W signed multiply.
  function automatic int prod_w(input int data_w, input int nco_w);
    return data_w + nco_w;
  endfunction

  // One guard bit so the complex sum/difference of two products cannot overflow.
  function automatic int sum_w(input int data_w, input int nco_w);
    return data_w + nco_w + 1;
  endfunction

endpackage

// File: rtl/ddc_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clip to OUT_W signed.
module ddc_round_sat #(
  parameter int IN_W  = 49,
  parameter int OUT_W = 32,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  // One extra bit so adding the rounding constant never wraps.
  localparam int EW = IN_W + 1;

  localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] rnd;

  always_comb begin
    rnd  = (EW'(din) + HALF) >>> SHIFT;
    dout = rnd[OUT_W-1:0];
    clip = 1'b0;
    if (rnd > MAXV) begin
      dout = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (rnd < MINV) begin
      dout = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/ddc_mixer_pipelined.sv
// Three-stage real/complex DDC mixer with round/saturate, valid/ready stall and clip counter.
module ddc_mixer_pipelined
  import ddc_mixer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NCO_W  = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 15,
  parameter int CH_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_complex,
  input  logic [DATA_W-1:0]    in_i,
  input  logic [DATA_W-1:0]    in_q,
  input  logic [NCO_W-1:0]     nco_cos,
  input  logic [NCO_W-1:0]     nco_sin,
  input  logic [CH_W-1:0]      in_chan,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_i,
  output logic [OUT_W-1:0]     out_q,
  output logic [CH_W-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam int PW = prod_w(DATA_W, NCO_W);
  localparam int SW = sum_w(DATA_W, NCO_W);

  logic adv;

  logic [STAGES:1] vld_q, vld_d;

  // Stage 1: registered operands; mode and tag travel with the sample.
  logic signed [DATA_W-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d;
  logic signed [NCO_W-1:0]  s1_cos_q, s1_cos_d, s1_sin_q, s1_sin_d;
  logic                     s1_cplx_q, s1_cplx_d;
  logic [CH_W-1:0]          s1_ch_q, s1_ch_d;

  // Stage 2: the four products.
  logic signed [PW-1:0] p_ic_q, p_ic_d, p_qs_q, p_qs_d, p_qc_q, p_qc_d, p_is_q, p_is_d;
  logic                 s2_cplx_q, s2_cplx_d;
  logic [CH_W-1:0]      s2_ch_q, s2_ch_d;

  // Stage 3: scaled outputs.
  logic [OUT_W-1:0]     out_i_q, out_i_d, out_q_q, out_q_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic                 sat_flag_q, sat_flag_d;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic signed [SW-1:0]    sum_i, sum_q;
  logic signed [OUT_W-1:0] rs_i, rs_q;
  logic                    clip_i, clip_q;

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d     = vld_q;
    s1_i_d    = s1_i_q;
    s1_q_d    = s1_q_q;
    s1_cos_d  = s1_cos_q;
    s1_sin_d  = s1_sin_q;
    s1_cplx_d = s1_cplx_q;
    s1_ch_d   = s1_ch_q;
    if (adv) begin
      vld_d     = {vld_q[STAGES-1:1], in_valid};
      s1_i_d    = in_i;
      s1_q_d    = in_q;
      s1_cos_d  = nco_cos;
      s1_sin_d  = nco_sin;
      s1_cplx_d = cfg_complex;
      s1_ch_d   = in_chan;
    end
  end

  always_comb begin
    p_ic_d    = p_ic_q;
    p_qs_d    = p_qs_q;
    p_qc_d    = p_qc_q;
    p_is_d    = p_is_q;
    s2_cplx_d = s2_cplx_q;
    s2_ch_d   = s2_ch_q;
    if (adv) begin
      p_ic_d    = PW'(s1_i_q) * PW'(s1_cos_q);
      p_qs_d    = PW'(s1_q_q) * PW'(s1_sin_q);
      p_qc_d    = PW'(s1_q_q) * PW'(s1_cos_q);
      p_is_d    = PW'(s1_i_q) * PW'(s1_sin_q);
      s2_cplx_d = s1_cplx_q;
      s2_ch_d   = s1_ch_q;
    end
  end

  // Complex path is x * e^-jwt; real path ignores the quadrature products.
  always_comb begin
    sum_i = s2_cplx_q ? SW'(p_ic_q) + SW'(p_qs_q) : SW'(p_ic_q);
    sum_q = s2_cplx_q ? SW'(p_qc_q) - SW'(p_is_q) : SW'(p_is_q);
  end

  ddc_round_sat #(.IN_W(SW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_i (
    .din (sum_i),
    .dout(rs_i),
    .clip(clip_i)
  );

  ddc_round_sat #(.IN_W(SW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_q (
    .din (sum_q),
    .dout(rs_q),
    .clip(clip_q)
  );

  always_comb begin
    out_i_d    = out_i_q;
    out_q_d    = out_q_q;
    out_ch_d   = out_ch_q;
    sat_flag_d = sat_flag_q;
    if (adv) begin
      out_i_d    = rs_i;
      out_q_d    = rs_q;
      out_ch_d   = s2_ch_q;
      sat_flag_d = clip_i | clip_q;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (vld_q[STAGES] && out_ready && sat_flag_q && sat_cnt_q != SAT_CNT_MAX)
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_cos_q   <= '0;
      s1_sin_q   <= '0;
      s1_cplx_q  <= 1'b0;
      s1_ch_q    <= '0;
      p_ic_q     <= '0;
      p_qs_q     <= '0;
      p_qc_q     <= '0;
      p_is_q     <= '0;
      s2_cplx_q  <= 1'b0;
      s2_ch_q    <= '0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      out_ch_q   <= '0;
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
      s1_cos_q   <= s1_cos_d;
      s1_sin_q   <= s1_sin_d;
      s1_cplx_q  <= s1_cplx_d;
      s1_ch_q    <= s1_ch_d;
      p_ic_q     <= p_ic_d;
      p_qs_q     <= p_qs_d;
      p_qc_q     <= p_qc_d;
      p_is_q     <= p_is_d;
      s2_cplx_q  <= s2_cplx_d;
      s2_ch_q    <= s2_ch_d;
      out_i_q    <= out_i_d;
      out_q_q    <= out_q_d;
      out_ch_q   <= out_ch_d;
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_chan  = out_ch_q;
  assign out_valid = vld_q[STAGES];
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_ddc_mixer_pipelined.sv
// Bench for ddc_mixer_pipelined: directed vector table, corner sequences, random stream vs model.
module tb_ddc_mixer_pipelined;

  localparam int DATA_W = 32;
  localparam int NCO_W  = 16;
  localparam int OUT_W  = 32;
  localparam int SHIFT  = 15;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_complex;
  logic [DATA_W-1:0] in_i, in_q;
  logic [NCO_W-1:0]  nco_cos, nco_sin;
  logic [CH_W-1:0]   in_chan;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_i, out_q;
  logic [CH_W-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              sat_clr;
  logic [15:0]       sat_count;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  ddc_mixer_pipelined #(
    .DATA_W(DATA_W), .NCO_W(NCO_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_complex(cfg_complex),
    .in_i(in_i), .in_q(in_q), .nco_cos(nco_cos), .nco_sin(nco_sin),
    .in_chan(in_chan), .in_valid(in_valid), .in_ready(in_ready),
    .out_i(out_i), .out_q(out_q), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  typedef struct {
    bit          cplx;
    logic [31:0] i, q;
    logic [15:0] c, s;
    logic [1:0]  ch;
    logic [31:0] ei, eq;
    bit          clip;
  } vec_t;

  typedef struct {
    logic [31:0] i, q;
    logic [1:0]  ch;
    bit          clip;
  } exp_t;

  vec_t tbl[7];
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mixer rules in plain 64-bit arithmetic.
  function automatic exp_t model(input bit cplx, input logic [31:0] i, input logic [31:0] q,
                                 input logic [15:0] c, input logic [15:0] s, input logic [1:0] ch);
    exp_t   e;
    longint si, sq, sc, ss, sum_i, sum_q, ri, rq;
    longint maxv, minv;
    maxv  = 64'sd2147483647;
    minv  = -64'sd2147483648;
    si    = longint'($signed(i));
    sq    = longint'($signed(q));
    sc    = longint'($signed(c));
    ss    = longint'($signed(s));
    sum_i = cplx ? si * sc + sq * ss : si * sc;
    sum_q = cplx ? sq * sc - si * ss : si * ss;
    ri    = (sum_i + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    rq    = (sum_q + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    e.clip = 1'b0;
    if (ri > maxv) begin ri = maxv; e.clip = 1'b1; end
    if (ri < minv) begin ri = minv; e.clip = 1'b1; end
    if (rq > maxv) begin rq = maxv; e.clip = 1'b1; end
    if (rq < minv) begin rq = minv; e.clip = 1'b1; end
    e.i  = ri[31:0];
    e.q  = rq[31:0];
    e.ch = ch;
    return e;
  endfunction

  task automatic drive(input bit cplx, input logic [31:0] i, input logic [31:0] q,
                       input logic [15:0] c, input logic [15:0] s, input logic [1:0] ch,
                       input bit v);
    cfg_complex = cplx;
    in_i        = i;
    in_q        = q;
    nco_cos     = c;
    nco_sin     = s;
    in_chan     = ch;
    in_valid    = v;
  endtask

  initial begin
    int exp_sat;
    int budget;

    tbl[0] = '{1'b0, 32'd1000, 32'd0, 16'h4000, 16'h0000, 2'd2, 32'd500, 32'd0, 1'b0};
    tbl[1] = '{1'b0, 32'd3, 32'd0, 16'h4000, 16'h0000, 2'd1, 32'd2, 32'd0, 1'b0};
    tbl[2] = '{1'b0, 32'hFFFFFFFD, 32'd0, 16'h4000, 16'h0000, 2'd3, 32'hFFFFFFFF, 32'd0, 1'b0};
    tbl[3] = '{1'b0, 32'd1000, 32'd77, 16'h0000, 16'h4000, 2'd0, 32'd0, 32'd500, 1'b0};
    tbl[4] = '{1'b1, 32'd100, 32'd200, 16'h4000, 16'h2000, 2'd1, 32'd100, 32'd75, 1'b0};
    tbl[5] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'h7FFF, 16'h7FFF, 2'd2, 32'h7FFFFFFF, 32'd0, 1'b1};
    tbl[6] = '{1'b0, 32'h80000000, 32'd0, 16'h8000, 16'h0000, 2'd3, 32'h7FFFFFFF, 32'd0, 1'b1};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed vectors, one at a time, with exact latency check.
    exp_sat = 0;
    foreach (tbl[k]) begin
      drive(tbl[k].cplx, tbl[k].i, tbl[k].q, tbl[k].c, tbl[k].s, tbl[k].ch, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_early_valid", k), out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), out_valid, 1);
      chk($sformatf("v%0d_out_i", k), out_i, tbl[k].ei);
      chk($sformatf("v%0d_out_q", k), out_q, tbl[k].eq);
      chk($sformatf("v%0d_out_chan", k), out_chan, tbl[k].ch);
      if (tbl[k].clip) exp_sat++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_sat_count", k), sat_count, exp_sat);
    end

    // Clear arriving on the same edge as a clipped beat wins.
    drive(tbl[5].cplx, tbl[5].i, tbl[5].q, tbl[5].c, tbl[5].s, tbl[5].ch, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("clr_prio_valid", out_valid, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    chk("clr_prio_count", sat_count, 0);

    // Reset with samples in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'd4000 + k, 32'd0, 16'h4000, 16'h1000, 2'(k), 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_drop", out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_no_ghost%0d", k), out_valid, 0);
    end
    drive(tbl[0].cplx, tbl[0].i, tbl[0].q, tbl[0].c, tbl[0].s, tbl[0].ch, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("post_rst_first_valid", out_valid, 1);
    chk("post_rst_first_i", out_i, tbl[0].ei);
    chk("post_rst_first_chan", out_chan, tbl[0].ch);
    @(posedge clk); #1;

    // Random stream with backpressure against the model.
    exp_sat = 0;
    budget  = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        logic [31:0] ri, rq;
        logic [15:0] rc, rs;
        ri = $urandom;
        rq = $urandom;
        rc = 16'($urandom);
        rs = 16'($urandom);
        if ($urandom_range(0, 3) == 0) ri = 32'($signed(ri) >>> 16);
        drive(1'($urandom), ri, rq, rc, rs, 2'($urandom), $urandom_range(0, 3) != 0);
        if (cyc < 16) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else          out_ready = $urandom_range(0, 2) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      chk("in_ready_adv", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL rnd_extra_beat: got beat i=%0h expected none", out_i);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("rnd_out_i", out_i, e.i);
          chk("rnd_out_q", out_q, e.q);
          chk("rnd_out_chan", out_chan, e.ch);
          if (e.clip && exp_sat < 65535) exp_sat++;
        end
      end
      if (in_valid && in_ready)
        expq.push_back(model(cfg_complex, in_i, in_q, nco_cos, nco_sin, in_chan));
      @(posedge clk); #1;
      budget++;
    end
    chk("rnd_drained", expq.size(), 0);
    chk("rnd_sat_count", sat_count, exp_sat);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
